tcp_tx_msg_poller: RTL and testbench

- Sits directly downstream of the TX message NoC interface's input half, and upstream of its output half.
- Holds application "send buffer space" requests: each is flowid + length + reply destination.
- Polls each pending flow's TX payload head/tail pointers round-robin.
- When free space ≥ requested length, emits a metadata grant (flowid, base_ptr = current tail, len, reply destination) for the NoC reply path.

---
 rtl/tcp_tx_msg_poller_pkg.sv | 37 +++
 rtl/tcp_tx_msg_poller_if.sv | 58 +++++
 rtl/tcp_tx_poller_table.sv | 66 ++++++
 rtl/tcp_tx_msg_poller.sv | 174 +++++++++++++++++
 tb/tb_tcp_tx_msg_poller.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tcp_tx_msg_poller_pkg.sv
// Shared types, widths and the free-space helper for the TX message poller.
package tcp_tx_msg_poller_pkg;

    localparam int FLOWID_W            = 8;
    localparam int TX_PAYLOAD_PTR_W    = 16;
    localparam int XY_WIDTH            = 8;
    localparam int MSG_SRC_FBITS_WIDTH = 4;

    localparam logic [TX_PAYLOAD_PTR_W:0] TX_BUF_SIZE = {1'b1, {TX_PAYLOAD_PTR_W{1'b0}}};

    typedef struct packed {
        logic [FLOWID_W-1:0]            flowid;
        logic [TX_PAYLOAD_PTR_W-1:0]    len;
        logic [XY_WIDTH-1:0]            dst_x;
        logic [XY_WIDTH-1:0]            dst_y;
        logic [MSG_SRC_FBITS_WIDTH-1:0] dst_fbits;
    } poller_slot_struct;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_CHECK   = 3'd3,
        ST_OUT     = 3'd4
    } poller_state_e;

    // Pointers carry one extra wrap bit, so used spans 0..2^W and free is W+1 bits.
    function automatic logic [TX_PAYLOAD_PTR_W:0] tx_free_space(
        input logic [TX_PAYLOAD_PTR_W:0] head,
        input logic [TX_PAYLOAD_PTR_W:0] tail
    );
        logic [TX_PAYLOAD_PTR_W:0] used;
        used = tail - head;
        return TX_BUF_SIZE - used;
    endfunction

endpackage

// File: rtl/tcp_tx_msg_poller_if.sv
// Request / pointer-read / grant channels of the TX message poller.
interface tcp_tx_msg_poller_if;
    import tcp_tx_msg_poller_pkg::*;

    logic                            noc_if_poller_msg_req_val;
    logic [FLOWID_W-1:0]             noc_if_poller_msg_req_flowid;
    logic [TX_PAYLOAD_PTR_W-1:0]     noc_if_poller_msg_req_len;
    logic [XY_WIDTH-1:0]             noc_if_poller_msg_dst_x;
    logic [XY_WIDTH-1:0]             noc_if_poller_msg_dst_y;
    logic [MSG_SRC_FBITS_WIDTH-1:0]  noc_if_poller_msg_dst_fbits;
    logic                            poller_noc_if_msg_req_rdy;

    logic                            poller_ptr_rd_req_val;
    logic [FLOWID_W-1:0]             poller_ptr_rd_req_flowid;
    logic                            ptr_poller_rd_req_rdy;
    logic                            ptr_poller_rd_resp_val;
    logic [TX_PAYLOAD_PTR_W:0]       ptr_poller_rd_resp_head;
    logic [TX_PAYLOAD_PTR_W:0]       ptr_poller_rd_resp_tail;
    logic                            poller_ptr_rd_resp_rdy;

    logic                            poller_msg_noc_if_meta_val;
    logic [FLOWID_W-1:0]             poller_msg_noc_if_flowid;
    logic [TX_PAYLOAD_PTR_W:0]       poller_msg_noc_if_base_ptr;
    logic [TX_PAYLOAD_PTR_W-1:0]     poller_msg_noc_if_len;
    logic [XY_WIDTH-1:0]             poller_msg_noc_if_dst_x;
    logic [XY_WIDTH-1:0]             poller_msg_noc_if_dst_y;
    logic [MSG_SRC_FBITS_WIDTH-1:0]  poller_msg_noc_if_dst_fbits;
    logic                            noc_if_poller_msg_meta_rdy;

    modport master (
        output noc_if_poller_msg_req_val, noc_if_poller_msg_req_flowid, noc_if_poller_msg_req_len,
        output noc_if_poller_msg_dst_x, noc_if_poller_msg_dst_y, noc_if_poller_msg_dst_fbits,
        input  poller_noc_if_msg_req_rdy,
        input  poller_ptr_rd_req_val, poller_ptr_rd_req_flowid,
        output ptr_poller_rd_req_rdy, ptr_poller_rd_resp_val,
        output ptr_poller_rd_resp_head, ptr_poller_rd_resp_tail,
        input  poller_ptr_rd_resp_rdy,
        input  poller_msg_noc_if_meta_val, poller_msg_noc_if_flowid, poller_msg_noc_if_base_ptr,
        input  poller_msg_noc_if_len, poller_msg_noc_if_dst_x, poller_msg_noc_if_dst_y,
        input  poller_msg_noc_if_dst_fbits,
        output noc_if_poller_msg_meta_rdy
    );

    modport slave (
        input  noc_if_poller_msg_req_val, noc_if_poller_msg_req_flowid, noc_if_poller_msg_req_len,
        input  noc_if_poller_msg_dst_x, noc_if_poller_msg_dst_y, noc_if_poller_msg_dst_fbits,
        output poller_noc_if_msg_req_rdy,
        output poller_ptr_rd_req_val, poller_ptr_rd_req_flowid,
        input  ptr_poller_rd_req_rdy, ptr_poller_rd_resp_val,
        input  ptr_poller_rd_resp_head, ptr_poller_rd_resp_tail,
        output poller_ptr_rd_resp_rdy,
        output poller_msg_noc_if_meta_val, poller_msg_noc_if_flowid, poller_msg_noc_if_base_ptr,
        output poller_msg_noc_if_len, poller_msg_noc_if_dst_x, poller_msg_noc_if_dst_y,
        output poller_msg_noc_if_dst_fbits,
        input  noc_if_poller_msg_meta_rdy
    );

endinterface

// File: rtl/tcp_tx_poller_table.sv
// Pending-request slot table: storage, lowest-free / duplicate-flow search, round-robin select.
module tcp_tx_poller_table
    import tcp_tx_msg_poller_pkg::*;
#(
    parameter int NUM_SLOTS = 8,
    parameter int SLOT_W    = $clog2(NUM_SLOTS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  poller_slot_struct wr_slot_i,
    input  logic              clr_en_i,
    input  logic [SLOT_W-1:0] clr_idx_i,
    input  logic [FLOWID_W-1:0] req_flowid_i,
    input  logic [SLOT_W-1:0] rr_ptr_i,
    input  logic [SLOT_W-1:0] rd_idx_i,
    output logic              rdy_o,
    output logic              any_valid_o,
    output logic [SLOT_W-1:0] sel_idx_o,
    output poller_slot_struct rd_slot_o
);

    poller_slot_struct    slot_q [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] valid_q, valid_d;
    logic [SLOT_W-1:0]    free_idx_s;
    logic                 dup_s;

    // Descending scans so the lowest free slot / nearest valid slot after rr_ptr wins.
    always_comb begin
        free_idx_s = '0;
        dup_s      = 1'b0;
        sel_idx_o  = rr_ptr_i;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            free_idx_s = valid_q[i] ? free_idx_s : SLOT_W'(i);
            dup_s      = dup_s | (valid_q[i] & (slot_q[i].flowid == req_flowid_i));
            sel_idx_o  = valid_q[rr_ptr_i + SLOT_W'(i)] ? (rr_ptr_i + SLOT_W'(i)) : sel_idx_o;
        end
    end

    assign rdy_o       = ~(&valid_q) & ~dup_s;
    assign any_valid_o = |valid_q;
    assign rd_slot_o   = slot_q[rd_idx_i];

    // Valid-bit next state; a slot freed this cycle still looks busy to the writer.
    always_comb begin
        valid_d             = valid_q;
        valid_d[clr_idx_i]  = valid_q[clr_idx_i] & ~clr_en_i;
        valid_d[free_idx_s] = valid_d[free_idx_s] | wr_en_i;
    end

    // Slot storage and valid bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            if (wr_en_i) begin
                slot_q[free_idx_s] <= wr_slot_i;
            end
        end
    end

endmodule

// File: rtl/tcp_tx_msg_poller.sv
// TX message poller: holds send-buffer-space requests and grants them once the flow has room.
// Optional statistics counters are built only when TCP_TX_POLLER_STATS_EN is defined.
module tcp_tx_msg_poller
    import tcp_tx_msg_poller_pkg::*;
#(
    parameter int NUM_SLOTS = 8,
    parameter int SLOT_W    = $clog2(NUM_SLOTS)
) (
    input  logic        clk,
    input  logic        rst_n,
    tcp_tx_msg_poller_if.slave bus,
    output logic [31:0] poller_stat_polls,
    output logic [31:0] poller_stat_grants
);

    poller_state_e             state_q, state_d;
    logic [SLOT_W-1:0]         cur_q, cur_d, rr_q, rr_d;
    logic [TX_PAYLOAD_PTR_W:0] head_q, head_d, tail_q, tail_d;
    logic                      en_q;

    logic                      tbl_rdy_s, any_valid_s, fits_s;
    logic                      accept_s, rd_hs_s, resp_hs_s, meta_hs_s;
    logic [SLOT_W-1:0]         sel_idx_s;
    poller_slot_struct         req_slot_s, cur_slot_s, meta_slot_s;
    logic                      req_rdy_s, rd_req_val_s, resp_rdy_s, meta_val_s;
    logic [FLOWID_W-1:0]       rd_flowid_s;
    logic [TX_PAYLOAD_PTR_W:0] meta_base_s;

    assign req_slot_s = '{flowid:    bus.noc_if_poller_msg_req_flowid,
                          len:       bus.noc_if_poller_msg_req_len,
                          dst_x:     bus.noc_if_poller_msg_dst_x,
                          dst_y:     bus.noc_if_poller_msg_dst_y,
                          dst_fbits: bus.noc_if_poller_msg_dst_fbits};

    assign accept_s  = req_rdy_s & bus.noc_if_poller_msg_req_val;
    assign rd_hs_s   = rd_req_val_s & bus.ptr_poller_rd_req_rdy;
    assign resp_hs_s = resp_rdy_s & bus.ptr_poller_rd_resp_val;
    assign meta_hs_s = meta_val_s & bus.noc_if_poller_msg_meta_rdy;
    assign fits_s    = ({1'b0, cur_slot_s.len} <= tx_free_space(head_q, tail_q));

    tcp_tx_poller_table #(
        .NUM_SLOTS (NUM_SLOTS),
        .SLOT_W    (SLOT_W)
    ) u_table (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en_i      (accept_s),
        .wr_slot_i    (req_slot_s),
        .clr_en_i     (meta_hs_s),
        .clr_idx_i    (cur_q),
        .req_flowid_i (bus.noc_if_poller_msg_req_flowid),
        .rr_ptr_i     (rr_q),
        .rd_idx_i     (cur_q),
        .rdy_o        (tbl_rdy_s),
        .any_valid_o  (any_valid_s),
        .sel_idx_o    (sel_idx_s),
        .rd_slot_o    (cur_slot_s)
    );

    // FSM state, current slot, round-robin pointer and captured pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
            rr_q    <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            rr_q    <= rr_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            en_q    <= 1'b1;
        end
    end

    // Next-state logic for the poll / check / grant sequence.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        rr_d    = rr_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            ST_IDLE: begin
                if (any_valid_s) begin
                    cur_d   = sel_idx_s;
                    state_d = ST_RD_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_REQ: begin
                state_d = rd_hs_s ? ST_RD_WAIT : ST_RD_REQ;
            end
            ST_RD_WAIT: begin
                if (resp_hs_s) begin
                    head_d  = bus.ptr_poller_rd_resp_head;
                    tail_d  = bus.ptr_poller_rd_resp_tail;
                    state_d = ST_CHECK;
                end else begin
                    state_d = ST_RD_WAIT;
                end
            end
            ST_CHECK: begin
                if (fits_s) begin
                    state_d = ST_OUT;
                end else begin
                    rr_d    = cur_q + SLOT_W'(1);
                    state_d = ST_IDLE;
                end
            end
            ST_OUT: begin
                if (meta_hs_s) begin
                    rr_d    = cur_q + SLOT_W'(1);
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_OUT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state; en_q keeps every output low while in reset.
    // resp_rdy stays high in IDLE so a response orphaned by reset is drained.
    always_comb begin
        req_rdy_s    = en_q & tbl_rdy_s;
        rd_req_val_s = (state_q == ST_RD_REQ);
        rd_flowid_s  = rd_req_val_s ? cur_slot_s.flowid : '0;
        resp_rdy_s   = en_q & ((state_q == ST_IDLE) | (state_q == ST_RD_WAIT));
        meta_val_s   = (state_q == ST_OUT);
        meta_slot_s  = meta_val_s ? cur_slot_s : '0;
        meta_base_s  = meta_val_s ? tail_q : '0;
    end

    assign bus.poller_noc_if_msg_req_rdy   = req_rdy_s;
    assign bus.poller_ptr_rd_req_val       = rd_req_val_s;
    assign bus.poller_ptr_rd_req_flowid    = rd_flowid_s;
    assign bus.poller_ptr_rd_resp_rdy      = resp_rdy_s;
    assign bus.poller_msg_noc_if_meta_val  = meta_val_s;
    assign bus.poller_msg_noc_if_flowid    = meta_slot_s.flowid;
    assign bus.poller_msg_noc_if_base_ptr  = meta_base_s;
    assign bus.poller_msg_noc_if_len       = meta_slot_s.len;
    assign bus.poller_msg_noc_if_dst_x     = meta_slot_s.dst_x;
    assign bus.poller_msg_noc_if_dst_y     = meta_slot_s.dst_y;
    assign bus.poller_msg_noc_if_dst_fbits = meta_slot_s.dst_fbits;

`ifdef TCP_TX_POLLER_STATS_EN
    logic [31:0] polls_q, grants_q;

    // Free-running wrap-around poll and grant counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            polls_q  <= 32'd0;
            grants_q <= 32'd0;
        end else begin
            polls_q  <= polls_q + {31'd0, rd_hs_s};
            grants_q <= grants_q + {31'd0, meta_hs_s};
        end
    end

    assign poller_stat_polls  = polls_q;
    assign poller_stat_grants = grants_q;
`else
    assign poller_stat_polls  = 32'd0;
    assign poller_stat_grants = 32'd0;
`endif

endmodule

// File: tb/tb_tcp_tx_msg_poller.sv
// Directed self-checking bench for tcp_tx_msg_poller with a one-cycle pointer-memory model.
module tb_tcp_tx_msg_poller;
    import tcp_tx_msg_poller_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] stat_polls, stat_grants;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          poll_cnt = 0;
    int          meta_hs_cnt = 0;
    int          acc_cyc, meta_cyc;
    int          m_flow, m_base, m_len, m_dx, m_dy, m_fb;
    int          resp_delay = 0;

    logic [TX_PAYLOAD_PTR_W:0] mem_head [256];
    logic [TX_PAYLOAD_PTR_W:0] mem_tail [256];
    logic                      rd_hs, resp_hs;
    logic [FLOWID_W-1:0]       rd_flow_cap;

    tcp_tx_msg_poller_if bus ();

    tcp_tx_msg_poller #(.NUM_SLOTS(8)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .bus                (bus),
        .poller_stat_polls  (stat_polls),
        .poller_stat_grants (stat_grants)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rd_hs       <= bus.poller_ptr_rd_req_val & bus.ptr_poller_rd_req_rdy;
        resp_hs     <= bus.ptr_poller_rd_resp_val & bus.poller_ptr_rd_resp_rdy;
        rd_flow_cap <= bus.poller_ptr_rd_req_flowid;
        if (bus.poller_ptr_rd_req_val && bus.ptr_poller_rd_req_rdy) poll_cnt <= poll_cnt + 1;
        if (bus.poller_msg_noc_if_meta_val && bus.noc_if_poller_msg_meta_rdy) meta_hs_cnt <= meta_hs_cnt + 1;
    end

    // Pointer memory: answers each read after resp_delay extra cycles, holds until accepted.
    initial begin : responder
        logic pend;
        int   dly;
        logic [FLOWID_W-1:0] pf;
        pend = 1'b0; dly = 0; pf = '0;
        forever begin
            @(negedge clk);
            if (resp_hs) bus.ptr_poller_rd_resp_val = 1'b0;
            if (rd_hs) begin pend = 1'b1; dly = resp_delay; pf = rd_flow_cap; end
            if (pend) begin
                if (dly == 0) begin
                    bus.ptr_poller_rd_resp_val  = 1'b1;
                    bus.ptr_poller_rd_resp_head = mem_head[pf];
                    bus.ptr_poller_rd_resp_tail = mem_tail[pf];
                    pend = 1'b0;
                end else begin
                    dly = dly - 1;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic set_req(input int fl, input int ln, input int dx, input int dy, input int fb);
        bus.noc_if_poller_msg_req_flowid = FLOWID_W'(fl);
        bus.noc_if_poller_msg_req_len    = TX_PAYLOAD_PTR_W'(ln);
        bus.noc_if_poller_msg_dst_x      = XY_WIDTH'(dx);
        bus.noc_if_poller_msg_dst_y      = XY_WIDTH'(dy);
        bus.noc_if_poller_msg_dst_fbits  = MSG_SRC_FBITS_WIDTH'(fb);
    endtask

    // Called at a negedge; returns at a negedge after the accept edge.
    task automatic send_req(input string tag, input int fl, input int ln,
                            input int dx, input int dy, input int fb);
        int n;
        n = 0;
        set_req(fl, ln, dx, dy, fb);
        bus.noc_if_poller_msg_req_val = 1'b1;
        #1;
        while (!bus.poller_noc_if_msg_req_rdy && n < 40) begin
            @(negedge clk); #1; n++;
        end
        check_eq({tag, "_accept"}, bus.poller_noc_if_msg_req_rdy, 1);
        @(posedge clk); #1;
        acc_cyc = cyc;
        bus.noc_if_poller_msg_req_val = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_meta(input string tag, input int bound);
        int n;
        n = 0;
        while (!bus.poller_msg_noc_if_meta_val && n < bound) begin
            @(negedge clk); n++;
        end
        check_eq({tag, "_meta_seen"}, bus.poller_msg_noc_if_meta_val, 1);
        m_flow = int'(bus.poller_msg_noc_if_flowid);
        m_base = int'(bus.poller_msg_noc_if_base_ptr);
        m_len  = int'(bus.poller_msg_noc_if_len);
        m_dx   = int'(bus.poller_msg_noc_if_dst_x);
        m_dy   = int'(bus.poller_msg_noc_if_dst_y);
        m_fb   = int'(bus.poller_msg_noc_if_dst_fbits);
        meta_cyc = cyc;
        bus.noc_if_poller_msg_meta_rdy = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
    endtask

    // Pending request must keep being polled without ever producing a grant.
    task automatic watch_denied(input string tag, input int ncyc);
        int p0, h0;
        p0 = poll_cnt; h0 = meta_hs_cnt;
        repeat (ncyc) @(negedge clk);
        check_eq({tag, "_no_grant"}, meta_hs_cnt - h0, 0);
        check_eq({tag, "_polled"}, (poll_cnt - p0) >= 3, 1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin mem_head[i] = '0; mem_tail[i] = '0; end
        rst_n = 1'b0;
        bus.noc_if_poller_msg_req_val   = 1'b0;
        set_req(0, 0, 0, 0, 0);
        bus.ptr_poller_rd_req_rdy       = 1'b1;
        bus.ptr_poller_rd_resp_val      = 1'b0;
        bus.ptr_poller_rd_resp_head     = '0;
        bus.ptr_poller_rd_resp_tail     = '0;
        bus.noc_if_poller_msg_meta_rdy  = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_req_rdy", bus.poller_noc_if_msg_req_rdy, 0);
        check_eq("rst_rd_req_val", bus.poller_ptr_rd_req_val, 0);
        check_eq("rst_resp_rdy", bus.poller_ptr_rd_resp_rdy, 0);
        check_eq("rst_meta_val", bus.poller_msg_noc_if_meta_val, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("idle_req_rdy", bus.poller_noc_if_msg_req_rdy, 1);

        // Empty buffer: immediate grant, fields echoed, 4-cycle latency.
        send_req("t1", 3, 100, 5, 6, 9);
        wait_meta("t1", 20);
        check_eq("t1_flow", m_flow, 3);
        check_eq("t1_base", m_base, 0);
        check_eq("t1_len", m_len, 100);
        check_eq("t1_dst_x", m_dx, 5);
        check_eq("t1_dst_y", m_dy, 6);
        check_eq("t1_fbits", m_fb, 9);
        check_eq("t1_latency", meta_cyc - acc_cyc, 4);
        set_req(3, 1, 0, 0, 0); #1;
        check_eq("t1_slot_freed", bus.poller_noc_if_msg_req_rdy, 1);

        // Only 50 bytes free until head advances to 60 (free 110).
        mem_tail[7] = 17'd65486;
        send_req("t2", 7, 100, 1, 2, 3);
        watch_denied("t2", 40);
        mem_head[7] = 17'd60;
        wait_meta("t2", 40);
        check_eq("t2_flow", m_flow, 7);
        check_eq("t2_base", m_base, 65486);
        check_eq("t2_len", m_len, 100);

        // Wrapped pointers: used 30, free 65506.
        mem_head[8] = 17'd131062; mem_tail[8] = 17'd20;
        mem_head[9] = 17'd131062; mem_tail[9] = 17'd20;
        send_req("t3a", 8, 65506, 0, 0, 0);
        wait_meta("t3a", 30);
        check_eq("t3a_flow", m_flow, 8);
        check_eq("t3a_base", m_base, 20);
        check_eq("t3a_len", m_len, 65506);
        send_req("t3b", 9, 65507, 0, 0, 0);
        watch_denied("t3b", 30);
        mem_head[9] = 17'd20;
        wait_meta("t3b", 30);
        check_eq("t3b_flow", m_flow, 9);
        check_eq("t3b_len", m_len, 65507);

        // Full buffer: len 0 passes, len 1 waits for one byte of room.
        mem_tail[11] = 17'd65536;
        mem_tail[12] = 17'd65536;
        send_req("full0", 11, 0, 0, 0, 0);
        wait_meta("full0", 30);
        check_eq("full0_flow", m_flow, 11);
        check_eq("full0_base", m_base, 65536);
        send_req("full1", 12, 1, 0, 0, 0);
        watch_denied("full1", 24);
        mem_head[12] = 17'd1;
        wait_meta("full1", 30);
        check_eq("full1_flow", m_flow, 12);
        check_eq("full1_len", m_len, 1);

        // Duplicate flow held off until the pending grant hands off.
        mem_head[3] = 17'd0; mem_tail[3] = 17'd65486;
        send_req("t4a", 3, 100, 0, 0, 0);
        repeat (10) @(negedge clk);
        set_req(3, 10, 0, 0, 0); #1;
        check_eq("t4_dup_blocked", bus.poller_noc_if_msg_req_rdy, 0);
        set_req(4, 10, 0, 0, 0); #1;
        check_eq("t4_other_flow_ok", bus.poller_noc_if_msg_req_rdy, 1);
        set_req(3, 10, 0, 0, 0);
        bus.noc_if_poller_msg_meta_rdy = 1'b0;
        mem_head[3] = 17'd60;
        for (int n = 0; n < 40 && !bus.poller_msg_noc_if_meta_val; n++) @(negedge clk);
        check_eq("t4_meta_stalled", bus.poller_msg_noc_if_meta_val, 1);
        check_eq("t4_dup_during_out", bus.poller_noc_if_msg_req_rdy, 0);
        bus.noc_if_poller_msg_meta_rdy = 1'b1;
        @(posedge clk); #1;
        check_eq("t4_rdy_after_grant", bus.poller_noc_if_msg_req_rdy, 1);
        @(negedge clk);
        send_req("t4b", 3, 10, 0, 0, 0);
        wait_meta("t4b", 30);
        check_eq("t4b_flow", m_flow, 3);
        check_eq("t4b_base", m_base, 65486);
        check_eq("t4b_len", m_len, 10);

        // Fill all slots with output stalled, then drain in slot order.
        bus.noc_if_poller_msg_meta_rdy = 1'b0;
        for (int k = 0; k < 8; k++) send_req("t5_fill", 20 + k, 20 + k, 0, 0, 0);
        set_req(40, 1, 0, 0, 0); #1;
        check_eq("t5_table_full", bus.poller_noc_if_msg_req_rdy, 0);
        for (int n = 0; n < 40 && !bus.poller_msg_noc_if_meta_val; n++) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq("t5_stall_hold", {bus.poller_msg_noc_if_meta_val, bus.poller_msg_noc_if_flowid,
                                       bus.poller_msg_noc_if_len, bus.poller_msg_noc_if_base_ptr},
                     {1'b1, 8'd20, 16'd20, 17'd0});
        end
        for (int k = 0; k < 8; k++) begin
            wait_meta("t5_drain", 30);
            check_eq("t5_rr_flow", m_flow, 20 + k);
            check_eq("t5_rr_len", m_len, 20 + k);
        end
`ifdef TCP_TX_POLLER_STATS_EN
        check_eq("stat_polls", stat_polls, poll_cnt);
        check_eq("stat_grants", stat_grants, meta_hs_cnt);
`endif

        // Reset while waiting on the pointer read: late response is drained, no grant.
        resp_delay = 3;
        send_req("t6", 30, 5, 0, 0, 0);
        for (int n = 0; n < 20 && !bus.poller_ptr_rd_req_val; n++) @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_resp_rdy", bus.poller_ptr_rd_resp_rdy, 0);
        check_eq("t6_rst_req_rdy", bus.poller_noc_if_msg_req_rdy, 0);
        check_eq("t6_rst_meta_val", bus.poller_msg_noc_if_meta_val, 0);
        check_eq("t6_rst_stat_polls", stat_polls, 0);
        check_eq("t6_rst_stat_grants", stat_grants, 0);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        begin
            int h0, p0;
            h0 = meta_hs_cnt; p0 = poll_cnt;
            repeat (8) @(negedge clk);
            check_eq("t6_resp_dropped", bus.ptr_poller_rd_resp_val, 0);
            check_eq("t6_no_grant", meta_hs_cnt - h0, 0);
            check_eq("t6_no_poll", poll_cnt - p0, 0);
            check_eq("t6_req_rdy", bus.poller_noc_if_msg_req_rdy, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
